// File: rtl/lcd_pkg.sv
// Shared LCD definitions: geometry, blank line, arbiter states and page layout.
package lcd_pkg;
  localparam int unsigned LCD_CHARS  = 16;
  localparam int unsigned LCD_LINE_W = 8 * LCD_CHARS;
  localparam int unsigned LCD_PAGE_W = 2 * LCD_LINE_W;

  localparam logic [LCD_LINE_W-1:0] LCD_BLANK_LINE = {LCD_CHARS{8'h20}};

  typedef enum logic {IDLE, HOLD} state_t;

  // Line 1 occupies the upper half of a page, char 0 in the MSB byte.
  typedef struct packed {
    logic [LCD_LINE_W-1:0] line_1;
    logic [LCD_LINE_W-1:0] line_2;
  } lcd_page_t;
endpackage

// File: rtl/lcd_rr_pick.sv
// Combinational round-robin selector: first set request at or above rr_ptr, wrapping.
module lcd_rr_pick
  import lcd_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   winner_c,
  output logic               valid_c
);

  int unsigned idx;

  always_comb begin
    winner_c = '0;
    valid_c  = 1'b0;
    idx      = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!valid_c && req[IDX_W'(idx)]) begin
        winner_c = IDX_W'(idx);
        valid_c  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lcd_msg_arbiter.sv
// Round-robin sharing of a 2x16 LCD between message sources, each page held HOLD_CYCLES.
// Optional macro LCD_ARB_PREEMPT_EN (undefined by default) makes requester 0 preempt holds.
module lcd_msg_arbiter
  import lcd_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned HOLD_CYCLES = 50000000,
  parameter int unsigned CNT_W       = 26
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*LCD_PAGE_W-1:0] msg_flat,
  input  logic [LCD_LINE_W-1:0]         default_line_1,
  input  logic [LCD_LINE_W-1:0]         default_line_2,
  output logic [NUM_REQ-1:0]            grant,
  output logic [$clog2(NUM_REQ)-1:0]    owner,
  output logic                          busy,
  output logic                          msg_done,
  output logic [LCD_LINE_W-1:0]         line_1,
  output logic [LCD_LINE_W-1:0]         line_2
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [CNT_W-1:0] hold_cnt;
  logic [IDX_W-1:0] pick_winner_c;
  logic             pick_valid_c;
  logic [IDX_W-1:0] next_ptr_c;
  logic             preempt_c;
  logic             expire_c;
  logic             take_c;
  lcd_page_t        pages [NUM_REQ];
  lcd_page_t        sel_page_c;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_page
    assign pages[g] = msg_flat[g*LCD_PAGE_W +: LCD_PAGE_W];
  end

  lcd_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req      (req),
    .rr_ptr   (rr_ptr),
    .winner_c (pick_winner_c),
    .valid_c  (pick_valid_c)
  );

`ifdef LCD_ARB_PREEMPT_EN
  assign preempt_c = (state == HOLD) && req[0] && (owner != '0);
`else
  assign preempt_c = 1'b0;
`endif

  assign sel_page_c = pages[pick_winner_c];
  assign next_ptr_c = (pick_winner_c == IDX_W'(NUM_REQ - 1)) ? '0 : pick_winner_c + IDX_W'(1);
  assign expire_c   = (state == HOLD) && (hold_cnt == HOLD_LAST) && !preempt_c;
  // Arbitrate while idle, or on hold expiry for back-to-back service.
  assign take_c     = pick_valid_c && ((state == IDLE) || expire_c);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      busy     <= 1'b0;
      msg_done <= 1'b0;
      owner    <= '0;
      rr_ptr   <= '0;
      hold_cnt <= '0;
      line_1   <= LCD_BLANK_LINE;
      line_2   <= LCD_BLANK_LINE;
    end else begin
      grant    <= '0;
      msg_done <= expire_c;
      if (preempt_c) begin
        // Urgent source 0 cuts the hold short; turn order is preserved.
        grant    <= NUM_REQ'(1);
        owner    <= '0;
        hold_cnt <= '0;
        line_1   <= pages[0].line_1;
        line_2   <= pages[0].line_2;
      end else if (take_c) begin
        grant    <= NUM_REQ'(1) << pick_winner_c;
        owner    <= pick_winner_c;
        rr_ptr   <= next_ptr_c;
        busy     <= 1'b1;
        hold_cnt <= '0;
        state    <= HOLD;
        line_1   <= sel_page_c.line_1;
        line_2   <= sel_page_c.line_2;
      end else if (state == IDLE) begin
        line_1 <= default_line_1;
        line_2 <= default_line_2;
      end else if (expire_c) begin
        busy     <= 1'b0;
        hold_cnt <= '0;
        state    <= IDLE;
      end else begin
        hold_cnt <= hold_cnt + CNT_W'(1);
      end
    end
  end

endmodule
